dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// CPU-side request/response bundle for the data-memory controller.
// The master modport is the CPU; the slave modport is dmem_ctrl.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one CPU request at a time against a synchronous
// single-port RAM, with lane extraction for loads and read-modify-write for sub-word stores.
module dmem_ctrl #(
  parameter int unsigned DEPTH = 262144
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  output logic        ram_en,
  output logic        ram_we,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, ACCESS, MERGE, WRITE, RESP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state, state_nxt;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, req_err, word_store;
  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data, merged_d;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign word_store    = we_q && (size_q == 2'd2);

  // Request legality is judged on the live inputs, in the cycle of acceptance.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = bus.req_addr[0];
      2'd2:    req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_W) req_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_di    = wdata_q;
    case (state)
      IDLE:   if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = word_store;
        state_nxt = word_store ? RESP : MERGE;
      end
      MERGE:  state_nxt = we_q ? WRITE : RESP;
      WRITE:  begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_di    = merged_q;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset pulses the RAM output-register reset and blocks any in-flight write.
    if (rst) begin
      ram_en = 1'b1;
      ram_we = 1'b0;
    end
  end

  assign ram_rst  = rst;
  assign ram_addr = addr_q;

  // Little-endian lane extraction and lane insertion on the word read back in MERGE.
  always_comb begin
    lane      = addr_q[1:0];
    byte_v    = ram_dout[{lane, 3'b000} +: 8];
    half_v    = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    load_data = ram_dout;
    merged_d  = ram_dout;
    case (size_q)
      2'd0: begin
        load_data = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        merged_d[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'd1: begin
        load_data = signed_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        merged_d  = addr_q[1] ? {wdata_q[15:0], ram_dout[15:0]}
                              : {ram_dout[31:16], wdata_q[15:0]};
      end
      default: ;
    endcase
  end

  // NOTE: request and datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
    if (state == MERGE) merged_q <= merged_d;
  end

  // Response registers change only on entry to RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_nxt == RESP && state != RESP) begin
      err_q   <= (state == IDLE);
      rdata_q <= (state == MERGE && !we_q) ? load_data : '0;
    end
  end

  assign bus.resp_valid = (state == RESP) && !rst;
  assign bus.resp_rdata = rst ? '0 : rdata_q;
  assign bus.resp_err   = rst ? 1'b0 : err_q;

endmodule
